// File: rtl/encoder_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_rr_arbiter
//  Description : Round-robin arbiter sharing one downstream resource between
//                N_REQ requesters. A rotating-priority encoder picks the first
//                active request at or after a pointer. A grant is held while
//                its request stays up, for at most MAX_HOLD cycles. When a
//                grant ends, the next one is issued on the same edge, so
//                there is no idle cycle between grants.
//
//  Ports       : clk      - single clock, rising edge
//                rst      - synchronous, active-high reset
//                req      - request vector (bit i = requester i), level-held
//                gnt      - registered one-hot grant, zero when idle
//                gnt_id   - binary index of the granted requester, 0 when idle
//                valid    - high while a grant is asserted
//                hold_cnt - cycles the current grant has been asserted
//                           (1..MAX_HOLD), 0 when idle
//
//  Revision    : 1.0 - initial release
// ============================================================================
module encoder_rr_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ID_W     = $clog2(N_REQ),
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             valid,
    output logic [CNT_W-1:0] hold_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    localparam logic [ID_W-1:0]  c_LAST_ID  = ID_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] c_MAX_HOLD = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [N_REQ-1:0] c_ONE_HOT0 = N_REQ'(1);

    // ------------------------------------------------------------------------
    // Rotating priority encoder: the first set bit of v found by scanning
    // p, p+1, ..., N_REQ-1, 0, ..., p-1. Returns 0 when v is empty; callers
    // only use the result when v is non-zero.
    // ------------------------------------------------------------------------
    function automatic logic [ID_W-1:0] f_pick(
        input logic [N_REQ-1:0] v,
        input logic [ID_W-1:0]  p
    );
        logic [ID_W-1:0] w_win;
        logic            w_found;
        int              w_idx;
        w_win   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (int'(p) + k) % N_REQ;
            if (!w_found && v[w_idx]) begin
                w_win   = ID_W'(w_idx);
                w_found = 1'b1;
            end
        end
        return w_win;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]       r_state;
    logic [ID_W-1:0]  r_ptr;
    logic [N_REQ-1:0] r_gnt;
    logic [ID_W-1:0]  r_gnt_id;
    logic [CNT_W-1:0] r_hold_cnt;

    logic [0:0]       w_state_nxt;
    logic [ID_W-1:0]  w_ptr_nxt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic [ID_W-1:0]  w_gnt_id_nxt;
    logic [CNT_W-1:0] w_hold_cnt_nxt;

    logic             w_release;
    logic [ID_W-1:0]  w_after_owner;
    logic [N_REQ-1:0] w_masked_req;
    logic [ID_W-1:0]  w_win;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_id   <= w_gnt_id_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // The owner gives up the resource when it drops its request or when its
    // tenure has reached the limit.
    assign w_release     = !req[r_gnt_id] || (r_hold_cnt == c_MAX_HOLD);
    assign w_after_owner = (r_gnt_id == c_LAST_ID) ? '0 : r_gnt_id + ID_W'(1);
    // r_gnt is the owner's one-hot, so this removes the outgoing owner from
    // the competition. It then cannot win straight back while others wait.
    assign w_masked_req  = req & ~r_gnt;

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_gnt_nxt      = r_gnt;
        w_gnt_id_nxt   = r_gnt_id;
        w_hold_cnt_nxt = r_hold_cnt;
        w_win          = '0;

        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_win          = f_pick(req, r_ptr);
                    w_gnt_nxt      = c_ONE_HOT0 << w_win;
                    w_gnt_id_nxt   = w_win;
                    w_hold_cnt_nxt = c_CNT_ONE;
                    w_state_nxt    = S_GRANT;
                end
            end

            S_GRANT: begin
                if (w_release) begin
                    w_ptr_nxt = w_after_owner;
                    if (|w_masked_req) begin
                        // Hand over on the same edge: no bubble.
                        w_win          = f_pick(w_masked_req, w_after_owner);
                        w_gnt_nxt      = c_ONE_HOT0 << w_win;
                        w_gnt_id_nxt   = w_win;
                        w_hold_cnt_nxt = c_CNT_ONE;
                    end else if (req[r_gnt_id]) begin
                        // Timed out, but nobody else wants the resource:
                        // re-grant the same owner with a fresh tenure.
                        w_hold_cnt_nxt = c_CNT_ONE;
                    end else begin
                        w_gnt_nxt      = '0;
                        w_gnt_id_nxt   = '0;
                        w_hold_cnt_nxt = '0;
                        w_state_nxt    = S_IDLE;
                    end
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + c_CNT_ONE;
                end
            end

            default: begin
                w_gnt_nxt      = '0;
                w_gnt_id_nxt   = '0;
                w_hold_cnt_nxt = '0;
                w_state_nxt    = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    always_comb begin
        gnt      = r_gnt;
        gnt_id   = r_gnt_id;
        valid    = (r_state == S_GRANT);
        hold_cnt = r_hold_cnt;
    end

endmodule
`default_nettype wire
